tdm_voice_scheduler: RTL and testbench
======================================

TDM_VOICE_SCHEDULER -- requirements
Module: tdm_voice_scheduler

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, meaning number of TDM voice slots per frame.
REQ-002 SHALL have parameter VOICE_BITS, default 2, meaning slot index width (log2 NUM_VOICES).
REQ-003 SHALL have parameter NOTE_W, default 7, meaning note tag width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports sys_clk and sys_rst_n.
REQ-005 sys_clk  in  1  pipeline clock, rising edge.
REQ-006 sys_rst_n  in  1  asynchronous active-low reset.
REQ-007 alloc_req  in  1  request to start a note; held high until alloc_ack.
REQ-008 alloc_note  in  NOTE_W  note tag for alloc_req; stable while alloc_req high.
REQ-009 alloc_ack  out  1  one-cycle pulse, allocation complete.
REQ-010 alloc_voice  out  VOICE_BITS  voice assigned; valid with alloc_ack.
REQ-011 alloc_stolen  out  1  assigned voice was stolen; valid with alloc_ack.
REQ-012 rel_req  in  1  request to end a note; held high until rel_ack.
REQ-013 rel_note  in  NOTE_W  note tag to release.
REQ-014 rel_ack  out  1  one-cycle pulse, release processed.
REQ-015 rel_hit  out  1  a matching voice was freed; valid with rel_ack.
REQ-016 tdm_chan_num  out  VOICE_BITS  current TDM slot.
REQ-017 tdm_chan_en  out  1  current slot's voice enabled.
REQ-018 tdm_chan_note  out  NOTE_W  current slot's note tag.
REQ-019 frame_start  out  1  high during slot 0.
REQ-020 active_count  out  VOICE_BITS+1  enabled voices in current frame.
REQ-021 norm_sel  out  2  summer divide select: 0=/1, 1=/2, 2=/3, 3=/4.

Function
REQ-022 Slot counter SHALL increment every cycle and wrap NUM_VOICES-1 -> 0; all TDM outputs SHALL be registered.
REQ-023 frame_start SHALL be 1 exactly when tdm_chan_num==0.
REQ-024 Voice table (enable, note per voice) SHALL have a working copy and a frame shadow; shadow loaded from working copy in the cycle the counter wraps to 0; tdm_chan_en/tdm_chan_note read the shadow only.
REQ-025 active_count SHALL be popcount of shadow enables, updated with shadow load; norm_sel = 0 for counts 0-1, else count-1.
REQ-026 Control FSM states: IDLE, ALLOC, REL, ACK.
REQ-027 IDLE: rel_req -> REL; else alloc_req -> ALLOC; release wins when both high.
REQ-028 ALLOC: choose lowest-index disabled voice; if none, steal voice at steal pointer, alloc_stolen=1; write enable=1, note=alloc_note; steal pointer advances by 1 (wraps) on every allocation -> ACK.
REQ-029 REL: clear enable of lowest-index enabled voice whose note==rel_note, rel_hit=1; no match -> rel_hit=0, table unchanged -> ACK.
REQ-030 ACK: pulse matching ack for one cycle -> IDLE; requester drops req after ack; FSM SHALL NOT re-accept a request in the ack cycle.
REQ-031 Request-to-ack latency SHALL be exactly 2 cycles after req first sampled high in IDLE.
REQ-032 Duplicate alloc of an already-sounding note SHALL allocate a new voice (no dedupe).

Reset
REQ-033 On sys_rst_n low, immediately: slot counter 0, all enables 0, notes 0, steal pointer 0, FSM IDLE, all outputs 0 (frame_start 0 until first post-reset edge registers slot 0).
REQ-034 Reset mid-handshake SHALL abort with no ack; requester re-issues.

Structure
REQ-035 Shared package tdm_pkg SHALL hold NUM_VOICES, VOICE_BITS, NOTE_W defaults and the norm_sel encoding constants.
REQ-036 One sub-module tdm_voice_alloc (priority free-voice finder plus note-match finder) SHALL be used.

Verification
REQ-037 Reset release -> tdm_chan_num 0,1,2,3,0...; frame_start every 4th cycle; active_count 0, norm_sel 0.
REQ-038 alloc_note 60,64,67 -> voices 0,1,2, alloc_stolen 0, ack 2 cycles after req; next frame active_count 3, norm_sel 2.
REQ-039 Five allocations, notes 60..64 -> fifth gets voice 0, alloc_stolen 1, tdm_chan_note slot0=64 next frame.
REQ-040 rel_note 64 with voices {60,64,67} -> rel_hit 1, voice 1 disabled from next frame; rel_note 50 -> rel_hit 0.
REQ-041 alloc_req and rel_req raised same cycle -> rel_ack first, alloc_ack 3 cycles later.
REQ-042 Enable written mid-frame (slot 2) -> tdm_chan_en unchanged until next frame_start.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared defaults, summer divide-select encodings and control FSM states
// for the TDM voice scheduler.
package tdm_pkg;

  localparam int NUM_VOICES_DEF = 4;
  localparam int VOICE_BITS_DEF = 2;
  localparam int NOTE_W_DEF     = 7;

  // Summer divide select: divide the mixed output by 1..4
  localparam logic [1:0] NORM_DIV1 = 2'd0;
  localparam logic [1:0] NORM_DIV2 = 2'd1;
  localparam logic [1:0] NORM_DIV3 = 2'd2;
  localparam logic [1:0] NORM_DIV4 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALLOC,
    ST_REL,
    ST_ACK
  } ctrl_state_t;

endpackage

// File: rtl/tdm_voice_alloc.sv
// Priority finders over the working voice table: lowest-index free voice
// and lowest-index enabled voice whose note tag matches.
module tdm_voice_alloc
  import tdm_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int VOICE_BITS = VOICE_BITS_DEF,
  parameter int NOTE_W     = NOTE_W_DEF
) (
  input  logic [NUM_VOICES-1:0]             voice_en,
  input  logic [NUM_VOICES-1:0][NOTE_W-1:0] voice_note,
  input  logic [NOTE_W-1:0]                 match_note,
  output logic                              free_found,
  output logic [VOICE_BITS-1:0]             free_idx,
  output logic                              hit_found,
  output logic [VOICE_BITS-1:0]             hit_idx
);

  // First disabled voice and first enabled note match, lowest index wins
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    hit_found  = 1'b0;
    hit_idx    = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!free_found && !voice_en[i]) begin
        free_found = 1'b1;
        free_idx   = VOICE_BITS'(i);
      end
      if (!hit_found && voice_en[i] && (voice_note[i] == match_note)) begin
        hit_found = 1'b1;
        hit_idx   = VOICE_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/tdm_voice_scheduler.sv
// TDM voice scheduler: allocates/releases voices through a req/ack
// handshake and streams a per-frame snapshot of the voice table one
// slot per cycle.
module tdm_voice_scheduler
  import tdm_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int VOICE_BITS = VOICE_BITS_DEF,
  parameter int NOTE_W     = NOTE_W_DEF
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  alloc_req,
  input  logic [NOTE_W-1:0]     alloc_note,
  output logic                  alloc_ack,
  output logic [VOICE_BITS-1:0] alloc_voice,
  output logic                  alloc_stolen,
  input  logic                  rel_req,
  input  logic [NOTE_W-1:0]     rel_note,
  output logic                  rel_ack,
  output logic                  rel_hit,
  output logic [VOICE_BITS-1:0] tdm_chan_num,
  output logic                  tdm_chan_en,
  output logic [NOTE_W-1:0]     tdm_chan_note,
  output logic                  frame_start,
  output logic [VOICE_BITS:0]   active_count,
  output logic [1:0]            norm_sel
);

  ctrl_state_t state_q, state_d;
  logic        is_rel_q, is_rel_d;

  logic [NUM_VOICES-1:0]             work_en, shadow_en;
  logic [NUM_VOICES-1:0][NOTE_W-1:0] work_note, shadow_note;
  logic [VOICE_BITS-1:0]             steal_q, slot_q, alloc_tgt;
  logic                              free_found, hit_found;
  logic [VOICE_BITS-1:0]             free_idx, hit_idx;
  logic [VOICE_BITS:0]               shadow_cnt, cnt_m1;
  logic [1:0]                        norm_d;
  logic                              slot_wrap;

  tdm_voice_alloc #(
    .NUM_VOICES (NUM_VOICES),
    .VOICE_BITS (VOICE_BITS),
    .NOTE_W     (NOTE_W)
  ) u_alloc (
    .voice_en   (work_en),
    .voice_note (work_note),
    .match_note (rel_note),
    .free_found (free_found),
    .free_idx   (free_idx),
    .hit_found  (hit_found),
    .hit_idx    (hit_idx)
  );

  assign alloc_tgt = free_found ? free_idx : steal_q;
  assign slot_wrap = (slot_q == VOICE_BITS'(NUM_VOICES - 1));

  // Control FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      is_rel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_rel_q <= is_rel_d;
    end
  end

  // Next state and ack pulses; release has priority, ACK never re-accepts
  always_comb begin
    state_d   = state_q;
    is_rel_d  = is_rel_q;
    alloc_ack = 1'b0;
    rel_ack   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rel_req) begin
          state_d  = ST_REL;
          is_rel_d = 1'b1;
        end else if (alloc_req) begin
          state_d  = ST_ALLOC;
          is_rel_d = 1'b0;
        end
      end
      ST_ALLOC, ST_REL: state_d = ST_ACK;
      ST_ACK: begin
        state_d   = ST_IDLE;
        alloc_ack = !is_rel_q;
        rel_ack   = is_rel_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Working voice table updates and handshake result registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      work_en      <= '0;
      work_note    <= '0;
      steal_q      <= '0;
      alloc_voice  <= '0;
      alloc_stolen <= 1'b0;
      rel_hit      <= 1'b0;
    end else begin
      case (state_q)
        ST_ALLOC: begin
          work_en[alloc_tgt]   <= 1'b1;
          work_note[alloc_tgt] <= alloc_note;
          alloc_voice          <= alloc_tgt;
          alloc_stolen         <= !free_found;
          steal_q              <= (steal_q == VOICE_BITS'(NUM_VOICES - 1)) ?
                                  '0 : steal_q + VOICE_BITS'(1);
        end
        ST_REL: begin
          rel_hit <= hit_found;
          if (hit_found) work_en[hit_idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Popcount of the frame snapshot and the matching divide select
  always_comb begin
    shadow_cnt = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      shadow_cnt = shadow_cnt + (VOICE_BITS + 1)'(shadow_en[i]);
    end
    cnt_m1 = shadow_cnt - (VOICE_BITS + 1)'(1);
    if (shadow_cnt <= (VOICE_BITS + 1)'(1)) norm_d = NORM_DIV1;
    else if (cnt_m1 > (VOICE_BITS + 1)'(3)) norm_d = NORM_DIV4;
    else                                    norm_d = cnt_m1[1:0];
  end

  // Slot counter, frame shadow and registered TDM outputs. The outputs
  // lag the counter by one cycle, so the shadow captured on the wrap edge
  // surfaces together with frame_start and the new active_count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slot_q        <= '0;
      shadow_en     <= '0;
      shadow_note   <= '0;
      tdm_chan_num  <= '0;
      tdm_chan_en   <= 1'b0;
      tdm_chan_note <= '0;
      frame_start   <= 1'b0;
      active_count  <= '0;
      norm_sel      <= '0;
    end else begin
      slot_q        <= slot_wrap ? '0 : slot_q + VOICE_BITS'(1);
      tdm_chan_num  <= slot_q;
      tdm_chan_en   <= shadow_en[slot_q];
      tdm_chan_note <= shadow_note[slot_q];
      frame_start   <= (slot_q == '0);
      if (slot_q == '0) begin
        active_count <= shadow_cnt;
        norm_sel     <= norm_d;
      end
      if (slot_wrap) begin
        shadow_en   <= work_en;
        shadow_note <= work_note;
      end
    end
  end

endmodule

// File: tb/tb_tdm_voice_scheduler.sv
// Self-checking bench for tdm_voice_scheduler: directed vector table,
// hand-written handshake corner cases, randomized traffic against a
// transaction-level voice model, and a per-cycle TDM stream monitor.
module tb_tdm_voice_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_req = 1'b0;
  logic [6:0] alloc_note = '0;
  logic       alloc_ack;
  logic [1:0] alloc_voice;
  logic       alloc_stolen;
  logic       rel_req = 1'b0;
  logic [6:0] rel_note = '0;
  logic       rel_ack;
  logic       rel_hit;
  logic [1:0] tdm_chan_num;
  logic       tdm_chan_en;
  logic [6:0] tdm_chan_note;
  logic       frame_start;
  logic [2:0] active_count;
  logic [1:0] norm_sel;

  int total_checks = 0;
  int passed_checks = 0;

  // Model of the voice table as seen by the requester
  bit         m_en[4];
  logic [6:0] m_note[4];
  int         m_steal;

  // Monitor's copy of the table as it stood at the last frame boundary
  int         slot_m;
  bit         shad_en[4];
  logic [6:0] shad_note[4];
  int         exp_cnt;

  always #5 clk = ~clk;

  tdm_voice_scheduler #(
    .NUM_VOICES (4),
    .VOICE_BITS (2),
    .NOTE_W     (7)
  ) dut (
    .sys_clk       (clk),
    .sys_rst_n     (rst_n),
    .alloc_req     (alloc_req),
    .alloc_note    (alloc_note),
    .alloc_ack     (alloc_ack),
    .alloc_voice   (alloc_voice),
    .alloc_stolen  (alloc_stolen),
    .rel_req       (rel_req),
    .rel_note      (rel_note),
    .rel_ack       (rel_ack),
    .rel_hit       (rel_hit),
    .tdm_chan_num  (tdm_chan_num),
    .tdm_chan_en   (tdm_chan_en),
    .tdm_chan_note (tdm_chan_note),
    .frame_start   (frame_start),
    .active_count  (active_count),
    .norm_sel      (norm_sel)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  function automatic void m_clear();
    for (int i = 0; i < 4; i++) begin
      m_en[i] = 0;
      m_note[i] = '0;
    end
    m_steal = 0;
  endfunction

  function automatic void m_alloc(input logic [6:0] n, output int v, output bit st);
    v = -1;
    for (int i = 0; i < 4; i++) if (v < 0 && !m_en[i]) v = i;
    st = (v < 0);
    if (st) v = m_steal;
    m_en[v] = 1;
    m_note[v] = n;
    m_steal = (m_steal + 1) % 4;
  endfunction

  function automatic void m_rel(input logic [6:0] n, output bit hit);
    hit = 0;
    for (int i = 0; i < 4; i++) begin
      if (!hit && m_en[i] && m_note[i] == n) begin
        hit = 1;
        m_en[i] = 0;
      end
    end
  endfunction

  // Every cycle: the stream must show the frame snapshot, slot by slot
  always @(posedge clk) begin
    logic [15:0] exp_v;
    int norm_m;
    if (!rst_n) begin
      slot_m = 0;
      exp_cnt = 0;
      for (int i = 0; i < 4; i++) begin
        shad_en[i] = 0;
        shad_note[i] = '0;
      end
      exp_v = '0;
    end else begin
      if (slot_m == 0) begin
        exp_cnt = 0;
        for (int i = 0; i < 4; i++) exp_cnt += int'(shad_en[i]);
      end
      norm_m = (exp_cnt <= 1) ? 0 : exp_cnt - 1;
      exp_v = {2'(slot_m), slot_m == 0, shad_en[slot_m], shad_note[slot_m],
               3'(exp_cnt), 2'(norm_m)};
      if (slot_m == 3) begin
        for (int i = 0; i < 4; i++) begin
          shad_en[i] = m_en[i];
          shad_note[i] = m_note[i];
        end
      end
      slot_m = (slot_m + 1) % 4;
    end
    #1;
    check("tdm_stream", 32'({tdm_chan_num, frame_start, tdm_chan_en, tdm_chan_note,
                             active_count, norm_sel}), 32'(exp_v));
  end

  task automatic do_alloc(input logic [6:0] n, output logic [1:0] v, output logic st);
    int lat = 0;
    int mv;
    bit mst;
    bit got = 0;
    v = '0;
    st = 1'b0;
    @(negedge clk);
    alloc_req = 1'b1;
    alloc_note = n;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk);
      #1;
      lat++;
      got = alloc_ack;
    end
    check("alloc_latency", 32'(lat), 32'd2);
    if (got) begin
      v = alloc_voice;
      st = alloc_stolen;
      m_alloc(n, mv, mst);
      check("alloc_voice_model", 32'(v), 32'(mv));
      check("alloc_stolen_model", 32'(st), 32'(mst));
    end
    @(negedge clk);
    alloc_req = 1'b0;
    @(posedge clk);
    #1;
    check("alloc_ack_one_cycle", 32'(alloc_ack), 32'd0);
  endtask

  task automatic do_rel(input logic [6:0] n, output logic hit);
    int lat = 0;
    bit mhit;
    bit got = 0;
    hit = 1'b0;
    @(negedge clk);
    rel_req = 1'b1;
    rel_note = n;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk);
      #1;
      lat++;
      got = rel_ack;
    end
    check("rel_latency", 32'(lat), 32'd2);
    if (got) begin
      hit = rel_hit;
      m_rel(n, mhit);
      check("rel_hit_model", 32'(hit), 32'(mhit));
    end
    @(negedge clk);
    rel_req = 1'b0;
    @(posedge clk);
    #1;
    check("rel_ack_one_cycle", 32'(rel_ack), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    alloc_req = 1'b0;
    rel_req = 1'b0;
    m_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_frame(input string nm);
    bit seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = frame_start;
    end
    check(nm, 32'(seen), 32'd1);
  endtask

  typedef struct {
    bit         is_rel;
    logic [6:0] note;
    logic [1:0] exp_voice;
    bit         exp_flag;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [1:0] v;
    logic       f;
    int         lat;
    bit         got;
    int         mv;
    bit         mst;
    bit         mhit;

    vecs[0] = '{0, 7'd60, 2'd0, 0};
    vecs[1] = '{0, 7'd64, 2'd1, 0};
    vecs[2] = '{0, 7'd67, 2'd2, 0};
    vecs[3] = '{1, 7'd64, 2'd0, 1};
    vecs[4] = '{1, 7'd50, 2'd0, 0};
    vecs[5] = '{0, 7'd70, 2'd1, 0};
    vecs[6] = '{0, 7'd67, 2'd3, 0};
    vecs[7] = '{0, 7'd60, 2'd1, 1};
    vecs[8] = '{1, 7'd67, 2'd0, 1};
    vecs[9] = '{0, 7'd5,  2'd2, 0};

    m_clear();
    #1;
    check("reset_outputs", 32'({tdm_chan_num, frame_start, tdm_chan_en, active_count,
                                norm_sel, alloc_ack, rel_ack}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_slot_num", 32'(tdm_chan_num), 32'd0);
    check("first_frame_start", 32'(frame_start), 32'd1);
    @(posedge clk);
    #1;
    check("second_slot_num", 32'(tdm_chan_num), 32'd1);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_rel) begin
        do_rel(vecs[i].note, f);
        check($sformatf("vec%0d_rel_hit", i), 32'(f), 32'(vecs[i].exp_flag));
      end else begin
        do_alloc(vecs[i].note, v, f);
        check($sformatf("vec%0d_voice", i), 32'(v), 32'(vecs[i].exp_voice));
        check($sformatf("vec%0d_stolen", i), 32'(f), 32'(vecs[i].exp_flag));
      end
    end

    // Three notes, then five: count/norm per frame and the steal wrap
    apply_reset();
    do_alloc(7'd60, v, f);
    do_alloc(7'd61, v, f);
    do_alloc(7'd62, v, f);
    wait_frame("frame_a");
    wait_frame("frame_b");
    check("count_three", 32'(active_count), 32'd3);
    check("norm_three", 32'(norm_sel), 32'd2);
    do_alloc(7'd63, v, f);
    do_alloc(7'd64, v, f);
    check("fifth_voice", 32'(v), 32'd0);
    check("fifth_stolen", 32'(f), 32'd1);
    wait_frame("frame_c");
    wait_frame("frame_d");
    check("slot0_note", 32'(tdm_chan_note), 32'd64);
    check("slot0_en", 32'(tdm_chan_en), 32'd1);
    check("count_four", 32'(active_count), 32'd4);
    check("norm_four", 32'(norm_sel), 32'd3);

    // Simultaneous requests: release first, allocation three cycles later
    @(negedge clk);
    rel_req = 1'b1;
    rel_note = 7'd62;
    alloc_req = 1'b1;
    alloc_note = 7'd90;
    lat = 0;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk);
      #1;
      lat++;
      got = rel_ack;
      check("no_alloc_ack_before_rel", 32'(alloc_ack), 32'd0);
    end
    check("both_rel_latency", 32'(lat), 32'd2);
    check("both_rel_hit", 32'(rel_hit), 32'd1);
    m_rel(7'd62, mhit);
    @(negedge clk);
    rel_req = 1'b0;
    lat = 0;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk);
      #1;
      lat++;
      got = alloc_ack;
    end
    check("both_alloc_delay", 32'(lat), 32'd3);
    check("both_alloc_voice", 32'(alloc_voice), 32'd2);
    check("both_alloc_stolen", 32'(alloc_stolen), 32'd0);
    m_alloc(7'd90, mv, mst);
    @(negedge clk);
    alloc_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-handshake aborts without an ack
    alloc_req = 1'b1;
    alloc_note = 7'd33;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    alloc_req = 1'b0;
    m_clear();
    got = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      got = got | alloc_ack;
    end
    check("abort_no_ack", 32'(got), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_alloc(7'd33, v, f);
    check("reissue_voice", 32'(v), 32'd0);
    check("reissue_stolen", 32'(f), 32'd0);

    // Randomized traffic with a small note pool to force hits and steals
    for (int t = 0; t < 80; t++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) do_rel(7'(40 + $urandom_range(0, 3)), f);
      else do_alloc(7'(40 + $urandom_range(0, 3)), v, f);
    end
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
